// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the CPU memory-port arbiter.
// Holds the sequencer state encoding, requester owner codes and address-mapping defaults.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam int MEM_AW_DEF     = 10;
    localparam int BYTE_SHIFT_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin grant: on a tie the requester that did not win last time wins.
// grant is one-hot (bit 0 = instruction fetch, bit 1 = data port).
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic       req_instr,
    input  logic       req_data,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant,
    output logic       next_grant
);

    always_comb begin
        grant      = 2'b00;
        next_grant = last_grant;
        if (en && (req_instr || req_data)) begin
            if (req_instr && req_data) begin
                next_grant = (last_grant == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
            end else if (req_data) begin
                next_grant = OWN_DATA;
            end else begin
                next_grant = OWN_INSTR;
            end
            grant = (next_grant == OWN_DATA) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word-addressed memory between the fetch port and the load/store port.
// Each request becomes a one-cycle memory command; reads are captured per port and acknowledged.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int BYTE_SHIFT = BYTE_SHIFT_DEF,
    parameter int DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [31:0]       I_ADDR,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_ACK,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [31:0]       D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ACK,
    output logic [31:0]       M_ADDR,
    output logic [DATA_W-1:0] M_DIN,
    output logic              M_WE,
    input  logic [DATA_W-1:0] M_DO,
    input  logic              M_RDY
);

    state_t            state, next_state;
    logic              last_grant;
    logic              owner;
    logic              we_r;
    logic [31:0]       m_addr_r;
    logic [DATA_W-1:0] m_din_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic [1:0]        grant;
    logic              next_grant;
    logic              arb_en;
    logic              addr_unused;

    // Byte address to word address; bits outside the memory window are dropped, so addresses wrap.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        logic [31:0] w;
        w             = '0;
        w[MEM_AW-1:0] = byte_addr[MEM_AW+BYTE_SHIFT-1:BYTE_SHIFT];
        return w;
    endfunction

    assign addr_unused = ^{I_ADDR, D_ADDR};
    assign arb_en      = (state == IDLE) && M_RDY;

    rr_arb2 u_arb (
        .req_instr (I_REQ),
        .req_data  (D_REQ),
        .last_grant(last_grant),
        .en        (arb_en),
        .grant     (grant),
        .next_grant(next_grant)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        M_WE       = 1'b0;
        I_ACK      = 1'b0;
        D_ACK      = 1'b0;
        case (state)
            IDLE: begin
                if (grant != 2'b00) next_state = ISSUE;
            end
            ISSUE: begin
                M_WE = we_r;
                if (M_RDY) next_state = we_r ? RESP : WAIT;
            end
            WAIT: begin
                if (M_RDY) next_state = RESP;
            end
            RESP: begin
                I_ACK      = (owner == OWN_INSTR);
                D_ACK      = (owner == OWN_DATA);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Command registers load on a grant; read data lands in the owning port's register only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= OWN_INSTR;
            owner      <= OWN_INSTR;
            we_r       <= 1'b0;
            m_addr_r   <= '0;
            m_din_r    <= '0;
            i_rdata_r  <= '0;
            d_rdata_r  <= '0;
        end else begin
            if (grant != 2'b00) begin
                last_grant <= next_grant;
                owner      <= next_grant;
                if (grant[1]) begin
                    m_addr_r <= word_addr(D_ADDR);
                    m_din_r  <= D_WDATA;
                    we_r     <= D_WE;
                end else begin
                    m_addr_r <= word_addr(I_ADDR);
                    we_r     <= 1'b0;
                end
            end
            if (state == WAIT && M_RDY) begin
                if (owner == OWN_DATA) begin
                    d_rdata_r <= M_DO;
                end else begin
                    i_rdata_r <= M_DO;
                end
            end
        end
    end

    assign M_ADDR  = m_addr_r;
    assign M_DIN   = m_din_r;
    assign I_RDATA = i_rdata_r;
    assign D_RDATA = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level schedule model (grant order, completion cycle, memory contents).
module tb_mem_port_arbiter;

    localparam int N = 14;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        I_REQ = 1'b0;
    logic [31:0] I_ADDR = '0;
    logic [31:0] I_RDATA;
    logic        I_ACK;
    logic        D_REQ = 1'b0;
    logic        D_WE = 1'b0;
    logic [31:0] D_ADDR = '0;
    logic [31:0] D_WDATA = '0;
    logic [31:0] D_RDATA;
    logic        D_ACK;
    logic [31:0] M_ADDR;
    logic [31:0] M_DIN;
    logic        M_WE;
    logic [31:0] M_DO;
    logic        M_RDY = 1'b1;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic        preload_req = 1'b0;

    logic        t_iack [0:N];
    logic        t_dack [0:N];
    logic        t_we   [0:N];
    logic [31:0] t_addr [0:N];
    logic [31:0] t_din  [0:N];
    logic [31:0] t_ird  [0:N];
    logic [31:0] t_drd  [0:N];

    int tests = 0;
    int fails = 0;

    mem_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK),
        .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_WE(M_WE), .M_DO(M_DO), .M_RDY(M_RDY)
    );

    always #5 CLK = ~CLK;

    // Registered-read single-port memory; word i preloaded with 2*i.
    always @(posedge CLK) begin
        if (preload_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(2 * i);
        end else if (M_RDY) begin
            if (M_WE) mem[M_ADDR[9:0]] <= M_DIN;
            M_DO <= mem[M_ADDR[9:0]];
        end
    end

    // Issue one request at the current falling edge (cycle 0) and trace cycles 1..N.
    task automatic xact(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall_from, input int stall_len);
        if (is_d) begin
            D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_WDATA = wdata;
        end else begin
            I_REQ = 1'b1; I_ADDR = addr;
        end
        M_RDY = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge CLK);
            t_iack[k] = I_ACK; t_dack[k] = D_ACK; t_we[k] = M_WE;
            t_addr[k] = M_ADDR; t_din[k] = M_DIN; t_ird[k] = I_RDATA; t_drd[k] = D_RDATA;
            if ((is_d && D_ACK) || (!is_d && I_ACK)) begin
                I_REQ = 1'b0; D_REQ = 1'b0;
            end
            M_RDY = !(k >= stall_from && k < stall_from + stall_len);
        end
        I_REQ = 1'b0; D_REQ = 1'b0; M_RDY = 1'b1;
    endtask

    function automatic int first_ack(input bit is_d);
        for (int k = 1; k <= N; k++) if (is_d ? t_dack[k] : t_iack[k]) return k;
        return -1;
    endfunction

    function automatic int ack_count(input bit is_d);
        int n = 0;
        for (int k = 1; k <= N; k++) if (is_d ? t_dack[k] : t_iack[k]) n++;
        return n;
    endfunction

    task automatic test_reset();
        RST = 1'b1; preload_req = 1'b1;
        @(negedge CLK);
        preload_req = 1'b0;
        @(negedge CLK);
        tests++; if ({I_ACK, D_ACK, M_WE} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got=%b exp=000", {I_ACK, D_ACK, M_WE}); end
        tests++; if (M_ADDR !== 32'h0) begin fails++; $display("FAIL reset_maddr got=%h exp=0", M_ADDR); end
        tests++; if (M_DIN !== 32'h0) begin fails++; $display("FAIL reset_mdin got=%h exp=0", M_DIN); end
        tests++; if ({I_RDATA, D_RDATA} !== 64'h0) begin fails++; $display("FAIL reset_rdata got=%h/%h exp=0", I_RDATA, D_RDATA); end
        RST = 1'b0;
    endtask

    task automatic test_fetch();
        xact(1'b0, 1'b0, 32'h10, 32'h0, 99, 0);
        tests++; if (t_addr[1] !== 32'd4) begin fails++; $display("FAIL fetch_maddr got=%h exp=4", t_addr[1]); end
        tests++; if (first_ack(1'b0) != 3) begin fails++; $display("FAIL fetch_latency got=%0d exp=3", first_ack(1'b0)); end
        tests++; if (ack_count(1'b0) != 1) begin fails++; $display("FAIL fetch_ackcount got=%0d exp=1", ack_count(1'b0)); end
        tests++; if (t_ird[3] !== 32'd8) begin fails++; $display("FAIL fetch_data got=%h exp=8", t_ird[3]); end
        tests++; if (ack_count(1'b1) != 0) begin fails++; $display("FAIL fetch_dack got=%0d exp=0", ack_count(1'b1)); end
    endtask

    task automatic test_store_load();
        int wecnt = 0;
        xact(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 99, 0);
        for (int k = 1; k <= N; k++) if (t_we[k]) wecnt++;
        tests++; if (wecnt != 1 || t_we[1] !== 1'b1) begin fails++; $display("FAIL store_we got=%0d/%b exp=1/1", wecnt, t_we[1]); end
        tests++; if (t_addr[1] !== 32'd8) begin fails++; $display("FAIL store_maddr got=%h exp=8", t_addr[1]); end
        tests++; if (t_din[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL store_mdin got=%h exp=deadbeef", t_din[1]); end
        tests++; if (first_ack(1'b1) != 2) begin fails++; $display("FAIL store_latency got=%0d exp=2", first_ack(1'b1)); end
        xact(1'b1, 1'b0, 32'h20, 32'h0, 99, 0);
        tests++; if (first_ack(1'b1) != 3) begin fails++; $display("FAIL load_latency got=%0d exp=3", first_ack(1'b1)); end
        tests++; if (t_drd[3] !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data got=%h exp=deadbeef", t_drd[3]); end
        tests++; if (t_ird[3] !== 32'd8) begin fails++; $display("FAIL load_irdata_kept got=%h exp=8", t_ird[3]); end
    endtask

    task automatic test_contention();
        int          ports [$];
        int          cycs  [$];
        logic [31:0] dats  [$];
        int          both = 0;
        int          exp_port [4] = '{1, 0, 1, 0};
        int          exp_cyc  [4] = '{3, 7, 11, 15};
        logic [31:0] exp_dat  [4] = '{32'd10, 32'd2, 32'd10, 32'd2};
        RST = 1'b1; I_REQ = 1'b1; D_REQ = 1'b1; D_WE = 1'b0;
        I_ADDR = 32'h4; D_ADDR = 32'h14;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (I_ACK && D_ACK) both++;
            if (D_ACK) begin ports.push_back(1); cycs.push_back(k); dats.push_back(D_RDATA); end
            if (I_ACK) begin ports.push_back(0); cycs.push_back(k); dats.push_back(I_RDATA); end
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        repeat (6) @(negedge CLK);
        tests++; if (both != 0) begin fails++; $display("FAIL cont_both_ack got=%0d exp=0", both); end
        tests++; if (ports.size() != 4) begin fails++; $display("FAIL cont_count got=%0d exp=4", ports.size()); end
        for (int i = 0; i < 4 && i < ports.size(); i++) begin
            tests++; if (ports[i] != exp_port[i] || cycs[i] != exp_cyc[i])
                begin fails++; $display("FAIL cont_order[%0d] got=port%0d@%0d exp=port%0d@%0d", i, ports[i], cycs[i], exp_port[i], exp_cyc[i]); end
            tests++; if (dats[i] !== exp_dat[i])
                begin fails++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, dats[i], exp_dat[i]); end
        end
    endtask

    task automatic test_stall();
        xact(1'b1, 1'b0, 32'hC, 32'h0, 1, 3);
        for (int k = 1; k <= 4; k++) begin
            tests++; if (t_addr[k] !== 32'd3) begin fails++; $display("FAIL stall_maddr[%0d] got=%h exp=3", k, t_addr[k]); end
        end
        tests++; if (first_ack(1'b1) != 6) begin fails++; $display("FAIL stall_latency got=%0d exp=6", first_ack(1'b1)); end
        tests++; if (ack_count(1'b1) != 1) begin fails++; $display("FAIL stall_ackcount got=%0d exp=1", ack_count(1'b1)); end
        tests++; if (t_drd[6] !== 32'd6) begin fails++; $display("FAIL stall_data got=%h exp=6", t_drd[6]); end
    endtask

    task automatic test_reset_mid();
        I_REQ = 1'b1; I_ADDR = 32'h10;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1; I_REQ = 1'b0;
        @(negedge CLK);
        tests++; if ({I_ACK, D_ACK, M_WE} !== 3'b000) begin fails++; $display("FAIL rstmid_ctrl got=%b exp=000", {I_ACK, D_ACK, M_WE}); end
        tests++; if ({I_RDATA, D_RDATA} !== 64'h0) begin fails++; $display("FAIL rstmid_rdata got=%h/%h exp=0", I_RDATA, D_RDATA); end
        RST = 1'b0;
        xact(1'b0, 1'b0, 32'h8, 32'h0, 99, 0);
        tests++; if (first_ack(1'b0) != 3) begin fails++; $display("FAIL rstmid_latency got=%0d exp=3", first_ack(1'b0)); end
        tests++; if (t_ird[3] !== 32'd4) begin fails++; $display("FAIL rstmid_data got=%h exp=4", t_ird[3]); end
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h40; D_WDATA = 32'h12345678;
        @(negedge CLK);
        tests++; if (M_WE !== 1'b1) begin fails++; $display("FAIL rststore_we got=%b exp=1", M_WE); end
        RST = 1'b1; D_REQ = 1'b0;
        @(negedge CLK);
        tests++; if (D_ACK !== 1'b0) begin fails++; $display("FAIL rststore_ack got=%b exp=0", D_ACK); end
        tests++; if (mem[16] !== 32'h12345678) begin fails++; $display("FAIL rststore_commit got=%h exp=12345678", mem[16]); end
        RST = 1'b0;
    endtask

    task automatic test_wrap();
        xact(1'b1, 1'b0, 32'h1003, 32'h0, 99, 0);
        tests++; if (t_addr[1] !== 32'd0) begin fails++; $display("FAIL wrap_maddr got=%h exp=0", t_addr[1]); end
        tests++; if (first_ack(1'b1) != 3) begin fails++; $display("FAIL wrap_latency got=%0d exp=3", first_ack(1'b1)); end
        tests++; if (t_drd[3] !== 32'd0) begin fails++; $display("FAIL wrap_data got=%h exp=0", t_drd[3]); end
    endtask

    // Model: serialized transactions; a grant happens on the first free cycle with a request,
    // ties go to the port that did not win last; reads ack 3 cycles later, stores 2.
    task automatic test_random();
        int          free_at = 0;
        int          last = 0;
        bit          tr_on = 1'b0;
        int          tr_port = 0, tr_issue = 0, tr_ack = 0, tr_word = 0;
        bit          tr_we = 1'b0;
        logic [31:0] tr_din = '0, tr_rd = '0, a;
        logic [31:0] exp_ird = '0, exp_drd = '0;
        logic        e_iack, e_dack, e_we;
        int          win;
        RST = 1'b1; preload_req = 1'b1; I_REQ = 1'b0; D_REQ = 1'b0; M_RDY = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(2 * i);
        @(negedge CLK);
        preload_req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c > 0) @(negedge CLK);
            if (tr_on && c == tr_ack && !tr_we) begin
                if (tr_port == 1) exp_drd = tr_rd; else exp_ird = tr_rd;
            end
            e_iack = tr_on && c == tr_ack && tr_port == 0;
            e_dack = tr_on && c == tr_ack && tr_port == 1;
            e_we   = tr_on && tr_we && c == tr_issue;
            tests++; if (I_ACK !== e_iack) begin fails++; $display("FAIL rnd_iack c=%0d got=%b exp=%b", c, I_ACK, e_iack); end
            tests++; if (D_ACK !== e_dack) begin fails++; $display("FAIL rnd_dack c=%0d got=%b exp=%b", c, D_ACK, e_dack); end
            tests++; if (M_WE !== e_we) begin fails++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, M_WE, e_we); end
            tests++; if (I_RDATA !== exp_ird) begin fails++; $display("FAIL rnd_irdata c=%0d got=%h exp=%h", c, I_RDATA, exp_ird); end
            tests++; if (D_RDATA !== exp_drd) begin fails++; $display("FAIL rnd_drdata c=%0d got=%h exp=%h", c, D_RDATA, exp_drd); end
            if (tr_on && c == tr_issue) begin
                tests++; if (M_ADDR !== 32'(tr_word)) begin fails++; $display("FAIL rnd_maddr c=%0d got=%h exp=%h", c, M_ADDR, tr_word); end
                if (tr_we) begin
                    tests++; if (M_DIN !== tr_din) begin fails++; $display("FAIL rnd_mdin c=%0d got=%h exp=%h", c, M_DIN, tr_din); end
                end
            end
            if (e_iack) I_REQ = 1'b0;
            else if (!I_REQ && $urandom_range(0, 1) == 1) begin I_REQ = 1'b1; I_ADDR = $urandom; end
            if (e_dack) D_REQ = 1'b0;
            else if (!D_REQ && $urandom_range(0, 1) == 1) begin
                D_REQ = 1'b1; D_WE = 1'($urandom_range(0, 1)); D_ADDR = $urandom; D_WDATA = $urandom;
            end
            if (c >= free_at && (I_REQ || D_REQ)) begin
                if (I_REQ && D_REQ) win = (last == 0) ? 1 : 0;
                else win = D_REQ ? 1 : 0;
                last     = win;
                tr_on    = 1'b1;
                tr_port  = win;
                tr_we    = (win == 1) && D_WE;
                a        = (win == 1) ? D_ADDR : I_ADDR;
                tr_word  = int'((a / 4) % 1024);
                tr_issue = c + 1;
                tr_ack   = c + (tr_we ? 2 : 3);
                free_at  = tr_ack + 1;
                if (tr_we) begin
                    tr_din = D_WDATA;
                    ref_mem[tr_word] = D_WDATA;
                end else begin
                    tr_rd = ref_mem[tr_word];
                end
            end
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
